// File: rtl/ic_power_ctrl_if.sv
// Signal bundle between the power sequencer and the supply monitor / NVM register wrappers.
// The sequencer takes the master modport; the environment side takes slave.
interface ic_power_ctrl_if #(
  parameter int NREG = 3
);
  logic            Vdd_warn;
  logic            Vdd_ok;
  logic [NREG-1:0] Dirty_val;
  logic [NREG-1:0] Backup_ack;
  logic            stand_by;
  logic            Pwr_off;
  logic [NREG-1:0] Backup_en;
  logic [NREG-1:0] Restore_en;
  logic [NREG-1:0] Rst_DrtyCtrl;
  logic            Bkp_err;

  modport master (
    input  Vdd_warn, Vdd_ok, Dirty_val, Backup_ack,
    output stand_by, Pwr_off, Backup_en, Restore_en, Rst_DrtyCtrl, Bkp_err
  );

  modport slave (
    output Vdd_warn, Vdd_ok, Dirty_val, Backup_ack,
    input  stand_by, Pwr_off, Backup_en, Restore_en, Rst_DrtyCtrl, Bkp_err
  );
endinterface

// File: rtl/ic_power_ctrl.sv
// Intermittent-computing power sequencer: freeze, back up dirty registers, gate power,
// then debounce the supply, restore every register and resume. All outputs are registered.
module ic_power_ctrl #(
  parameter int NREG          = 3,
  parameter int ACK_TIMEOUT   = 16,
  parameter int STABLE_CYCLES = 8
) (
  input logic             Clk,
  input logic             Rst,
  ic_power_ctrl_if.master pif
);
  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT) + 1;
  localparam int ST_W  = $clog2(STABLE_CYCLES) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREG - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  ST_TARGET = ST_W'(STABLE_CYCLES);
  localparam logic [NREG-1:0]  FIRST_OH  = NREG'(1);

  typedef enum logic [2:0] {
    S_RUN, S_DRAIN, S_BACKUP, S_CLEAR, S_OFF, S_WAKE, S_RESTORE, S_RESUME
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [ST_W-1:0]  st_cnt_q, st_cnt_d;
  logic [NREG-1:0]  backup_en_q, backup_en_d;
  logic [NREG-1:0]  restore_en_q, restore_en_d;
  logic [NREG-1:0]  rst_drty_q, rst_drty_d;
  logic             stand_by_q, stand_by_d;
  logic             pwr_off_q, pwr_off_d;
  logic             bkp_err_q, bkp_err_d;
  logic [NREG-1:0]  next_onehot;
  logic             bkp_done;

  assign idx_inc = idx_q + 1'b1;

  // One-hot select for the register after the current one.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_next_oh
    assign next_onehot[gi] = (idx_inc == IDX_W'(gi));
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    to_cnt_d     = to_cnt_q;
    st_cnt_d     = st_cnt_q;
    backup_en_d  = '0;
    restore_en_d = '0;
    rst_drty_d   = '0;
    bkp_err_d    = bkp_err_q;
    bkp_done     = 1'b0;

    case (state_q)
      S_RUN: begin
        if (pif.Vdd_warn) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d     = S_BACKUP;
        idx_d       = '0;
        to_cnt_d    = '0;
        backup_en_d = FIRST_OH & pif.Dirty_val;
      end
      S_BACKUP: begin
        // A clean register enters with no request raised and is skipped in one cycle.
        if (|backup_en_q) begin
          if (pif.Backup_ack[idx_q]) begin
            bkp_done = 1'b1;
          end else if (to_cnt_q == TO_LAST) begin
            bkp_done  = 1'b1;
            bkp_err_d = 1'b1;
          end else begin
            to_cnt_d    = to_cnt_q + 1'b1;
            backup_en_d = backup_en_q;
          end
        end else begin
          bkp_done = 1'b1;
        end
        if (bkp_done) begin
          to_cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d    = S_CLEAR;
            rst_drty_d = '1;
          end else begin
            idx_d       = idx_inc;
            backup_en_d = next_onehot & pif.Dirty_val;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_OFF;
      end
      S_OFF: begin
        if (pif.Vdd_ok) begin
          state_d  = S_WAKE;
          st_cnt_d = '0;
        end
      end
      S_WAKE: begin
        if (!pif.Vdd_ok || pif.Vdd_warn) begin
          st_cnt_d = '0;
          state_d  = S_OFF;
        end else if (st_cnt_q + 1'b1 == ST_TARGET) begin
          st_cnt_d     = '0;
          state_d      = S_RESTORE;
          idx_d        = '0;
          restore_en_d = FIRST_OH;
        end else begin
          st_cnt_d = st_cnt_q + 1'b1;
        end
      end
      S_RESTORE: begin
        // Registers still match their NVM copy, so a warning here needs no new backup.
        if (pif.Vdd_warn) begin
          state_d = S_OFF;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_RESUME;
        end else begin
          idx_d        = idx_inc;
          restore_en_d = next_onehot;
        end
      end
      S_RESUME: begin
        state_d = pif.Vdd_warn ? S_DRAIN : S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    stand_by_d = (state_d != S_RUN);
    pwr_off_d  = (state_d == S_OFF) || (state_d == S_WAKE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_RUN;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      st_cnt_q     <= '0;
      backup_en_q  <= '0;
      restore_en_q <= '0;
      rst_drty_q   <= '0;
      stand_by_q   <= 1'b0;
      pwr_off_q    <= 1'b0;
      bkp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      to_cnt_q     <= to_cnt_d;
      st_cnt_q     <= st_cnt_d;
      backup_en_q  <= backup_en_d;
      restore_en_q <= restore_en_d;
      rst_drty_q   <= rst_drty_d;
      stand_by_q   <= stand_by_d;
      pwr_off_q    <= pwr_off_d;
      bkp_err_q    <= bkp_err_d;
    end
  end

  assign pif.stand_by     = stand_by_q;
  assign pif.Pwr_off      = pwr_off_q;
  assign pif.Backup_en    = backup_en_q;
  assign pif.Restore_en   = restore_en_q;
  assign pif.Rst_DrtyCtrl = rst_drty_q;
  assign pif.Bkp_err      = bkp_err_q;
endmodule

// File: tb/tb_ic_power_ctrl.sv
// Directed bench for ic_power_ctrl: a sequential protocol model drives per-cycle expectations,
// and each scenario adds hand-computed latency / pulse-count checks.
module tb_ic_power_ctrl;
  localparam int NREG          = 3;
  localparam int ACK_TIMEOUT   = 16;
  localparam int STABLE_CYCLES = 8;
  localparam int P_RUN = 0, P_DRAIN = 1, P_OFF = 2;

  logic Clk = 1'b0;
  logic rst_n = 1'b0;
  logic model_on = 1'b0;
  logic [NREG-1:0] ack_mask = '1;
  int total = 0;
  int bad = 0;

  logic [NREG-1:0] exp_bkp, exp_res, exp_drty;
  logic exp_sb, exp_pwr, exp_err;

  ic_power_ctrl_if #(.NREG(NREG)) pif ();

  ic_power_ctrl #(
    .NREG(NREG), .ACK_TIMEOUT(ACK_TIMEOUT), .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .Clk(Clk),
    .Rst(rst_n),
    .pif(pif)
  );

  initial forever #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Wrapper model: each ack arrives in the third cycle its request has been high.
  initial begin : ack_resp
    int cnt [NREG];
    for (int r = 0; r < NREG; r++) cnt[r] = 0;
    pif.Backup_ack = '0;
    forever begin
      @(negedge Clk);
      for (int r = 0; r < NREG; r++) begin
        if (pif.Backup_en[r]) cnt[r]++; else cnt[r] = 0;
        pif.Backup_ack[r] = ack_mask[r] && (cnt[r] == 3);
      end
    end
  end

  // Protocol model written as a sequential walk through the power cycle.
  initial begin : model
    int go, waited, run;
    bit hit, aborted;
    exp_bkp = '0; exp_res = '0; exp_drty = '0;
    exp_sb = 1'b0; exp_pwr = 1'b0; exp_err = 1'b0;
    wait (model_on);
    go = P_RUN;
    forever begin
      if (go == P_RUN) begin
        exp_sb = 1'b0; exp_pwr = 1'b0; exp_bkp = '0; exp_res = '0; exp_drty = '0;
        @(posedge Clk);
        while (!pif.Vdd_warn) @(posedge Clk);
        go = P_DRAIN;
      end else if (go == P_DRAIN) begin
        exp_sb = 1'b1; exp_pwr = 1'b0; exp_res = '0;
        @(posedge Clk);
        for (int r = 0; r < NREG; r++) begin
          exp_bkp = '0;
          if (pif.Dirty_val[r]) begin
            exp_bkp[r] = 1'b1;
            waited = 0; hit = 0;
            while (!hit) begin
              @(posedge Clk);
              waited++;
              if (pif.Backup_ack[r]) hit = 1;
              else if (waited == ACK_TIMEOUT) begin hit = 1; exp_err = 1'b1; end
            end
          end else begin
            @(posedge Clk);
          end
        end
        exp_bkp = '0; exp_drty = '1;
        @(posedge Clk);
        exp_drty = '0;
        go = P_OFF;
      end else begin
        exp_pwr = 1'b1; exp_sb = 1'b1; exp_res = '0;
        @(posedge Clk);
        while (!pif.Vdd_ok) @(posedge Clk);
        run = 0; aborted = 0;
        while (!aborted && run < STABLE_CYCLES) begin
          @(posedge Clk);
          if (!pif.Vdd_ok || pif.Vdd_warn) aborted = 1; else run++;
        end
        if (!aborted) begin
          exp_pwr = 1'b0;
          for (int r = 0; r < NREG && !aborted; r++) begin
            exp_res = '0; exp_res[r] = 1'b1;
            @(posedge Clk);
            if (pif.Vdd_warn) aborted = 1;
          end
          exp_res = '0;
          if (!aborted) begin
            @(posedge Clk);
            go = pif.Vdd_warn ? P_DRAIN : P_RUN;
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge Clk);
      if (model_on) begin
        chk("stand_by",     8'(pif.stand_by),     8'(exp_sb));
        chk("Pwr_off",      8'(pif.Pwr_off),      8'(exp_pwr));
        chk("Backup_en",    8'(pif.Backup_en),    8'(exp_bkp));
        chk("Restore_en",   8'(pif.Restore_en),   8'(exp_res));
        chk("Rst_DrtyCtrl", 8'(pif.Rst_DrtyCtrl), 8'(exp_drty));
        chk("Bkp_err",      8'(pif.Bkp_err),      8'(exp_err));
      end
    end
  end

  initial begin : stim
    int k, n001, n010, n100, nrst, f001, f100, ferr, nres;
    logic [NREG-1:0] res_log [3];
    pif.Vdd_warn = 1'b0; pif.Vdd_ok = 1'b0; pif.Dirty_val = '0;

    // Reset held with random inputs.
    repeat (4) begin
      @(negedge Clk);
      pif.Vdd_warn  = 1'($urandom);
      pif.Vdd_ok    = 1'($urandom);
      pif.Dirty_val = 3'($urandom_range(0, 7));
      #1;
      chk("rst_sb",   8'(pif.stand_by), 8'd0);
      chk("rst_pwr",  8'(pif.Pwr_off), 8'd0);
      chk("rst_bkp",  8'(pif.Backup_en), 8'd0);
      chk("rst_res",  8'(pif.Restore_en), 8'd0);
      chk("rst_drty", 8'(pif.Rst_DrtyCtrl), 8'd0);
      chk("rst_err",  8'(pif.Bkp_err), 8'd0);
    end
    @(negedge Clk);
    pif.Vdd_warn = 1'b0; pif.Vdd_ok = 1'b0; pif.Dirty_val = '0;
    rst_n = 1'b1; model_on = 1'b1;
    repeat (10) @(negedge Clk);
    chk("idle_sb", 8'(pif.stand_by), 8'd0);
    $display("txn: reset and idle");

    // Minimum warn-to-off latency, nothing dirty.
    pif.Vdd_warn = 1'b1; k = 0;
    while (k < 40 && !pif.Pwr_off) begin
      @(negedge Clk); k++;
      if (k == 1) begin pif.Vdd_warn = 1'b0; chk("A_drain_sb", 8'(pif.stand_by), 8'd1); end
    end
    chk("A_latency", 8'(k), 8'd6);
    $display("txn: clean power-down, Pwr_off after %0d cycles", k);

    // Wake debounce: 5 high, 1 low, then a long run.
    pif.Vdd_ok = 1'b1; repeat (5) @(negedge Clk);
    pif.Vdd_ok = 1'b0; @(negedge Clk);
    pif.Vdd_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge Clk); chk("W_pwr_hold", 8'(pif.Pwr_off), 8'd1); end
    @(negedge Clk); chk("W_pwr_fall", 8'(pif.Pwr_off), 8'd0); chk("W_res0", 8'(pif.Restore_en), 8'h1);
    @(negedge Clk); chk("W_res1", 8'(pif.Restore_en), 8'h2);
    @(negedge Clk); chk("W_res2", 8'(pif.Restore_en), 8'h4);
    @(negedge Clk); chk("W_resume_sb", 8'(pif.stand_by), 8'd1); chk("W_resume_res", 8'(pif.Restore_en), 8'h0);
    @(negedge Clk); chk("W_run_sb", 8'(pif.stand_by), 8'd0);
    $display("txn: debounced wake and restore");

    // Full save with dirty 101 and acks after two cycles.
    pif.Dirty_val = 3'b101; ack_mask = '1; pif.Vdd_ok = 1'b0; pif.Vdd_warn = 1'b1;
    k = 0; n001 = 0; n010 = 0; n100 = 0; nrst = 0; f001 = -1; f100 = -1;
    while (k < 60 && !pif.Pwr_off) begin
      @(negedge Clk); k++;
      if (k == 1) pif.Vdd_warn = 1'b0;
      if (pif.Backup_en == 3'b001) begin n001++; if (f001 < 0) f001 = k; end
      if (pif.Backup_en == 3'b010) n010++;
      if (pif.Backup_en == 3'b100) begin n100++; if (f100 < 0) f100 = k; end
      if (pif.Rst_DrtyCtrl == 3'b111) nrst++;
    end
    chk("B_n001", 8'(n001), 8'd3); chk("B_n010", 8'(n010), 8'd0); chk("B_n100", 8'(n100), 8'd3);
    chk("B_f001", 8'(f001), 8'd2); chk("B_f100", 8'(f100), 8'd6);
    chk("B_nrst", 8'(nrst), 8'd1); chk("B_latency", 8'(k), 8'd10); chk("B_err", 8'(pif.Bkp_err), 8'd0);
    $display("txn: full save dirty=101, Pwr_off after %0d cycles", k);
    pif.Vdd_ok = 1'b1; k = 0;
    while (k < 100 && pif.stand_by) begin @(negedge Clk); k++; end
    chk("B_wake_done", 8'(pif.stand_by), 8'd0);

    // Backup timeout on register 1.
    pif.Dirty_val = 3'b010; ack_mask = '0; pif.Vdd_ok = 1'b0; pif.Vdd_warn = 1'b1;
    k = 0; n010 = 0; ferr = -1;
    while (k < 80 && !pif.Pwr_off) begin
      @(negedge Clk); k++;
      if (k == 1) pif.Vdd_warn = 1'b0;
      if (pif.Backup_en == 3'b010) n010++;
      if (pif.Bkp_err && ferr < 0) ferr = k;
    end
    chk("C_n010", 8'(n010), 8'd16); chk("C_ferr", 8'(ferr), 8'd19);
    chk("C_latency", 8'(k), 8'd21); chk("C_err", 8'(pif.Bkp_err), 8'd1);
    $display("txn: backup timeout, Bkp_err at cycle %0d", ferr);

    // Warning in the middle of restore.
    pif.Vdd_ok = 1'b1; k = 0;
    while (k < 40 && pif.Restore_en != 3'b010) begin @(negedge Clk); k++; end
    chk("D_seen010", 8'(pif.Restore_en), 8'h2);
    pif.Vdd_warn = 1'b1; pif.Vdd_ok = 1'b0;
    @(negedge Clk);
    chk("D_pwr", 8'(pif.Pwr_off), 8'd1); chk("D_res", 8'(pif.Restore_en), 8'h0);
    pif.Vdd_warn = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("D_hold_res", 8'(pif.Restore_en), 8'h0); chk("D_hold_pwr", 8'(pif.Pwr_off), 8'd1);
    end
    pif.Vdd_ok = 1'b1; k = 0; nres = 0;
    while (k < 100 && pif.stand_by) begin
      @(negedge Clk); k++;
      if (pif.Restore_en != '0) begin
        if (nres < 3) res_log[nres] = pif.Restore_en;
        nres++;
      end
    end
    chk("D_wake_done", 8'(pif.stand_by), 8'd0); chk("D_nres", 8'(nres), 8'd3);
    if (nres >= 3) begin
      chk("D_log0", 8'(res_log[0]), 8'h1); chk("D_log1", 8'(res_log[1]), 8'h2); chk("D_log2", 8'(res_log[2]), 8'h4);
    end
    chk("D_err_sticky", 8'(pif.Bkp_err), 8'd1);
    $display("txn: warn during restore, later full restore of %0d registers", nres);

    // Asynchronous reset while register 0 is being backed up.
    pif.Dirty_val = 3'b001; ack_mask = '1; pif.Vdd_ok = 1'b0; pif.Vdd_warn = 1'b1; k = 0;
    while (k < 20 && pif.Backup_en != 3'b001) begin
      @(negedge Clk); k++;
      if (k == 1) pif.Vdd_warn = 1'b0;
    end
    chk("E_seen001", 8'(pif.Backup_en), 8'h1); chk("E_err_before", 8'(pif.Bkp_err), 8'd1);
    model_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("E_bkp", 8'(pif.Backup_en), 8'h0); chk("E_sb", 8'(pif.stand_by), 8'd0);
    chk("E_err", 8'(pif.Bkp_err), 8'd0); chk("E_pwr", 8'(pif.Pwr_off), 8'd0);
    $display("txn: async reset mid-backup");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ic_power_ctrl.md
# ic_power_ctrl

Intermittent-computing power sequencer that sits directly upstream of the control unit and its pipeline-register wrappers. It produces the `stand_by` freeze and `Pwr_off` signals those stages consume, and it drives the per-register `Backup_en` / `Restore_en` / `Rst_DrtyCtrl` strobes of the NVM-backed register wrappers. On a supply warning it freezes the pipeline, backs up every dirty register, and cuts power. When the supply is stable again it restores all registers and resumes execution.

## Interface
Parameters:
- `NREG`, 3: number of backed-up register wrappers (CU FET/EXE, EXE/MEM, MEM/WB).
- `ACK_TIMEOUT`, 16: maximum cycles to wait for one `Backup_ack`.
- `STABLE_CYCLES`, 8: consecutive `Vdd_ok` cycles required before wake-up.

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `Vdd_warn`  in  1  supply-low warning; level-sensitive.
- `Vdd_ok`  in  1  supply-good indication; level-sensitive.
- `Dirty_val`  in  NREG  per-register dirty flag from the wrappers.
- `Backup_ack`  in  NREG  per-register backup-complete acknowledge.
- `stand_by`  out  1  pipeline freeze; high in every state except RUN.
- `Pwr_off`  out  1  power gate; high only in OFF and WAKE.
- `Backup_en`  out  NREG  one-hot backup request; held until ack or timeout.
- `Restore_en`  out  NREG  one-hot single-cycle restore strobe.
- `Rst_DrtyCtrl`  out  NREG  clears the dirty flags; all bits pulse together for one cycle.
- `Bkp_err`  out  1  sticky flag: a backup timed out; cleared only by `Rst`.

## Operation
States: RUN, DRAIN, BACKUP, CLEAR, OFF, WAKE, RESTORE, RESUME.

- **Reset:** state RUN; index 0; counters 0. All outputs are 0, including `Bkp_err`.
- **RUN:** if `Vdd_warn`=1, go to DRAIN.
- **DRAIN:** one cycle with `stand_by`=1 so the in-flight clock edge settles. Then set index i=0 and go to BACKUP.
- **BACKUP:** handles register i.
  - If `Dirty_val[i]`=0: skip in one cycle, no `Backup_en`.
  - Otherwise assert `Backup_en[i]`. Wait until `Backup_ack[i]`=1, or until `ACK_TIMEOUT` cycles have passed with `Backup_en[i]` high. A timeout sets `Bkp_err`.
  - Then increment i. After i=NREG-1 completes, go to CLEAR.
  - Deassertion of `Vdd_warn` during BACKUP is ignored; a started backup always runs to the end.
- **CLEAR:** `Rst_DrtyCtrl` is all ones for one cycle, then go to OFF.
- **OFF:** `Pwr_off`=1. On the first cycle with `Vdd_ok`=1, go to WAKE.
- **WAKE:** `Pwr_off`=1. A stability counter counts consecutive `Vdd_ok`=1 cycles.
  - `Vdd_ok`=0 or `Vdd_warn`=1: clear the counter and return to OFF.
  - When the count reaches `STABLE_CYCLES`: set i=0 and go to RESTORE.
- **RESTORE:** `Restore_en[i]`=1 for exactly one cycle for every i in 0..NREG-1, regardless of dirty state. Then go to RESUME.
  - `Vdd_warn`=1 during RESTORE: go straight to OFF. No backup is needed because the registers still equal the NVM copy.
- **RESUME:** one cycle with `stand_by`=1, then RUN with `stand_by`=0.
  - `Vdd_warn`=1 in RESUME: go to DRAIN instead of RUN.
- **Encoding rules:**
  - At most one bit of `Backup_en` is high at a time; same for `Restore_en`.
  - `Backup_en`, `Restore_en` and `Rst_DrtyCtrl` are never asserted in the same cycle.
- **Widths:** the index register is clog2(NREG) bits wide (minimum 1). The timeout counter and stability counter are clog2 of their parameter plus 1 bits wide; neither counter wraps.
- **Reset mid-operation:** an asynchronous `Rst` in any state forces RUN and all outputs to 0 immediately. No backup completion is implied.

## Timing
- All outputs are registered (Moore); there is no combinational path from inputs to outputs.
- `Vdd_warn` sampled high in RUN at edge t:
  - `stand_by`=1 from t+1 (DRAIN).
  - First possible `Backup_en` at t+2.
- Backup of register i:
  - Dirty with ack: `Backup_en[i]` drops the cycle after `Backup_ack[i]` is sampled high, and the next index starts that same cycle.
  - Not dirty: costs 1 cycle.
  - Timed out: costs `ACK_TIMEOUT` cycles.
- Minimum warn-to-`Pwr_off` latency with no dirty registers: 1 (DRAIN) + NREG (BACKUP) + 1 (CLEAR) = NREG+2 cycles after entering DRAIN. With defaults, `Pwr_off` rises at t+6.
- Wake-up: `Pwr_off` falls on the edge after the `STABLE_CYCLES`-th consecutive `Vdd_ok` sample in WAKE.
  - RESTORE then takes NREG cycles and RESUME takes 1 cycle.
  - With defaults, `stand_by` falls 4 cycles after `Pwr_off` falls.

## Test plan
- **Reset values:** `Rst`=0 with random inputs -> all outputs 0. Release `Rst` with `Vdd_warn`=0 -> outputs stay 0 indefinitely.
- **Full save:** `Dirty_val`=3'b101, each ack returned 2 cycles after its `Backup_en`.
  - Required: `Backup_en` sequence 001 (3 cycles), one idle skip cycle for register 1, 100 (3 cycles).
  - Then `Rst_DrtyCtrl`=111 for 1 cycle, then `Pwr_off`=1. `Bkp_err`=0.
- **Timeout:** `Dirty_val`=3'b010 with no ack -> `Backup_en`=010 held for exactly 16 cycles, then `Bkp_err`=1 (sticky) and the sequence continues to OFF.
- **Wake debounce:** in OFF, `Vdd_ok` high 5 cycles, low 1, high 8.
  - Required: `Pwr_off` falls only after the 8-cycle run.
  - Then `Restore_en` = 001, 010, 100 on consecutive cycles, and `stand_by`=0 after the RESUME cycle.
- **Warn during restore:** `Vdd_warn`=1 in the cycle `Restore_en`=010 -> next state OFF with `Pwr_off`=1 and no further `Restore_en`. A later wake restores all 3 registers.
- **Async reset mid-backup:** `Rst`=0 while `Backup_en`=001 -> `Backup_en`, `stand_by` and `Bkp_err` all go to 0 without waiting for a clock edge.
